load_extend_unit: RTL and testbench
===================================

Name: load_extend_unit

Overview:
- Memory-read side of the datapath's immediate and data extension path.
- Accepts a load request (byte, half or word, signed or unsigned) from the CPU core and issues one aligned 32-bit word read to data memory.
- Waits for the memory acknowledge, then selects the addressed byte or halfword, sign- or zero-extends it to 32 bits, and returns it through a valid/ready response handshake.
- Detects misaligned accesses and memory timeouts and reports them as errors.

Parameters:
- ADDR_W, 32, request and memory address width (bits).
- ACK_TIMEOUT, 255, maximum cycles spent in MEM waiting for mem_ack before a bus error is reported; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
- mem_rd  output  1  memory read strobe.
- mem_addr  output  ADDR_W  word-aligned read address.
- mem_rdata  input  32  memory read data; valid when mem_ack = 1.
- mem_ack  input  1  read data valid this cycle.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  32  extended load result.
- resp_misalign  output  1  misaligned or illegal-size request.
- resp_buserr  output  1  memory timeout.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- States: IDLE, MEM, RESP. rst_n low forces IDLE immediately.
- Reset values: mem_rd = 0, mem_addr = 0, resp_valid = 0, resp_data = 0, resp_misalign = 0, resp_buserr = 0, timeout counter = 0.
- req_ready = (state == IDLE), combinational. It reads 1 during and after reset.
- IDLE:
  - On req_valid && req_ready, latch addr, size and unsigned.
  - A request is misaligned if size = 11, or (size = 01 && addr[0]), or (size = 10 && addr[1:0] != 0).
  - Misaligned: go to RESP with resp_misalign = 1 and resp_data = 0. mem_rd is never asserted.
  - Otherwise: go to MEM. mem_rd = 1 and mem_addr = {addr[ADDR_W-1:2], 2'b00}, both registered, so they appear the cycle after acceptance. Clear the counter.
- MEM:
  - mem_rd and mem_addr are held stable until mem_ack.
  - mem_ack may arrive in the first MEM cycle.
  - On mem_ack: deassert mem_rd, register the extended result into resp_data, and go to RESP. resp_valid is high the cycle after mem_ack.
  - Otherwise the counter increments. When the counter reaches ACK_TIMEOUT-1 without an ack: deassert mem_rd, set resp_buserr = 1 and resp_data = 0, and go to RESP.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- RESP:
  - resp_valid = 1. resp_data and the flags are held until resp_valid && resp_ready.
  - On that cycle, go to IDLE and clear resp_valid and both flags.
  - The next request can be accepted the cycle after the handshake; there is no back-to-back acceptance.
- mem_ack outside MEM is ignored.
- Byte lanes are big-endian. Offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Halfword offset 0 = [31:16], 2 = [15:0].
- Extension:
  - byte: {24{s & b[7]}, b}
  - half: {16{s & h[15]}, h}
  - word: passed unchanged
  - where s = ~unsigned.
- Reset mid-operation: any state returns to IDLE. An outstanding memory read is abandoned, and a late mem_ack after reset is ignored.
- Request inputs are sampled only on acceptance; changes afterwards have no effect.

Test Plan:
- Memory word 0x8899AABB at 0x100, ack after 2 cycles:
  - lb 0x101 -> resp_data 0xFFFFFF99
  - lbu 0x103 -> 0x000000BB
  - lh 0x102 -> 0xFFFFAABB
  - lhu 0x100 -> 0x00008899
  - lw 0x100 -> 0x8899AABB
  - every case: mem_addr = 0x100, no flags set.
- Misalignment: lh 0x101, lw 0x102, size 11 -> resp_misalign = 1, resp_data = 0, mem_rd stays 0 throughout.
- Timing and backpressure:
  - Zero-wait ack (ack in the first MEM cycle) -> resp_valid exactly 1 cycle later.
  - resp_ready held low for 5 cycles -> resp_data and resp_valid stable and req_ready = 0 throughout.
- Timeout: no ack, ACK_TIMEOUT = 4 -> mem_rd high for exactly 4 cycles, then resp_buserr = 1. Ack coincident with the final count -> normal data, no buserr.
- Reset mid-MEM: rst_n low while mem_rd = 1 -> mem_rd, resp_valid and the flags are 0 asynchronously and req_ready = 1. A later mem_ack produces no response.

Source files
------------

// File: rtl/load_extend_unit.sv
// load_extend_unit
// Memory-read side of the load path. Accepts one byte/half/word load at a
// time, issues one aligned 32-bit read, then extracts the addressed big-endian
// lane, sign- or zero-extends it, and returns it over a response handshake.
// Misaligned/illegal requests and acknowledge timeouts come back as errors.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A valid source holds its payload stable until
// that edge. req_ready is a pure function of state; resp_valid and the
// response payload are registered and hold until the response transfer.

module load_extend_unit #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // load request from the core
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  // data memory read port
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  // load response to the core
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_misalign,
  output logic              resp_buserr,
  // current FSM state, for debug and checkers
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // 16 bits covers the full legal ACK_TIMEOUT range of 1..65535.
  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                misalign_q, misalign_d;
  logic                buserr_q, buserr_d;
  logic                req_misaligned;

  // Select the big-endian lane addressed by off and extend it to 32 bits.
  function automatic logic [31:0] extend_load(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic        s;
    s = ~uns;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: extend_load = {{24{s & b[7]}}, b};
      SZ_HALF: extend_load = {{16{s & h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

  // Illegal size, odd halfword address or non-word-aligned word address.
  always_comb begin
    req_misaligned = (req_size == 2'b11)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
  end

  // Next-state and registered-output logic for the IDLE/MEM/RESP sequence.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    misalign_d   = misalign_q;
    buserr_d     = buserr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Request fields are captured here and never looked at again.
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          if (req_misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = 32'h0;
            misalign_d   = 1'b1;
            buserr_d     = 1'b0;
          end else begin
            state_d    = S_MEM;
            mem_rd_d   = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            cnt_d      = '0;
          end
        end
      end

      S_MEM: begin
        // An ack on the final counted cycle still completes normally.
        if (mem_ack) begin
          state_d      = S_RESP;
          mem_rd_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = extend_load(mem_rdata, size_q, off_q, uns_q);
          misalign_d   = 1'b0;
          buserr_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          mem_rd_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = 32'h0;
          misalign_d   = 1'b0;
          buserr_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          misalign_d   = 1'b0;
          buserr_d     = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        mem_rd_d     = 1'b0;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
        buserr_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      misalign_q   <= 1'b0;
      buserr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      misalign_q   <= misalign_d;
      buserr_q     <= buserr_d;
    end
  end

  // Output mapping; req_ready depends on state only, so it is 1 in reset.
  always_comb begin
    req_ready     = (state_q == S_IDLE);
    mem_rd        = mem_rd_q;
    mem_addr      = mem_addr_q;
    resp_valid    = resp_valid_q;
    resp_data     = resp_data_q;
    resp_misalign = misalign_q;
    resp_buserr   = buserr_q;
    dbg_state     = state_q;
  end

`ifndef SYNTHESIS
  // The read strobe is only ever up while waiting for memory.
  a_rd_only_in_mem: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rd |-> (state_q == S_MEM));

  // Without ack or timeout the read request is held unchanged.
  a_rd_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_MEM && !mem_ack && cnt_q != CNT_LAST) |=> (mem_rd && $stable(mem_addr)));

  // A response never carries both error flags.
  a_one_error: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_misalign && resp_buserr));
`endif

endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: directed cases from the load/extension rules,
// misalignment, backpressure, timeout, reset mid-read, then random loads
// checked against a lane-shift reference model.

module tb_load_extend_unit;

  localparam int ADDR_W = 32;
  localparam int T      = 4;   // ACK_TIMEOUT used for this bench

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = 32'h0;
  logic              mem_ack;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_data;
  logic              resp_misalign;
  logic              resp_buserr;
  logic [1:0]        dbg_state;

  load_extend_unit #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_misalign(resp_misalign),
    .resp_buserr  (resp_buserr),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_model[logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int   ack_delay  = 2;
  bit   ack_en     = 1'b1;
  logic manual_ack = 1'b0;
  logic auto_ack   = 1'b0;
  int   wcnt       = 0;

  assign mem_ack = auto_ack | manual_ack;

  // Acks the ack_delay-th MEM cycle (0 = first) with the model word.
  always @(negedge clk) begin
    auto_ack  = 1'b0;
    mem_rdata = $urandom;
    if (mem_rd && ack_en) begin
      if (wcnt == ack_delay) begin
        auto_ack  = 1'b1;
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEADBEEF;
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // Big-endian lane = byte (3-off) counting from the LSB; extend arithmetically.
  function automatic void ref_load(input logic [31:0] addr, input logic [1:0] size,
                                   input logic uns, input logic [31:0] word,
                                   output logic [31:0] data, output bit mis);
    int unsigned off;
    int unsigned v;
    off  = addr[1:0];
    mis  = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
    data = 32'h0;
    if (mis) return;
    case (size)
      2'd0: begin
        v = (word >> (8 * (3 - off))) % 256;
        if (!uns && v >= 128) v = v - 256;
        data = v;
      end
      2'd1: begin
        v = (word >> (8 * (2 - off))) % 65536;
        if (!uns && v >= 32768) v = v - 65536;
        data = v;
      end
      default: data = word;
    endcase
  endfunction

  // ---------------- driver: one complete load ----------------
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input int dly, input int rdy_dly, input string tag);
    logic [31:0] word, exp_data, e, waddr;
    bit          mis, exp_bus;
    int          exp_lat, exp_rd, lat, rd_cnt, addr_bad, w;
    waddr = {addr[31:2], 2'b00};
    word  = mem_model.exists(waddr) ? mem_model[waddr] : 32'hDEADBEEF;
    ref_load(addr, size, uns, word, exp_data, mis);
    ack_delay = dly;
    exp_bus   = !mis && (!ack_en || dly >= T);
    if (mis) begin
      exp_lat = 1;  exp_rd = 0;
    end else if (exp_bus) begin
      exp_lat = T + 1;  exp_rd = T;
    end else begin
      exp_lat = dly + 2;  exp_rd = dly + 1;
    end
    exp_q.push_back(exp_bus ? 32'h0 : exp_data);

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_req_ready"}, req_ready, 1);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; it must have no effect.
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));

    lat = 0; rd_cnt = 0; addr_bad = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (mem_rd) begin
        rd_cnt++;
        if (mem_addr !== waddr) addr_bad++;
      end
      if (resp_valid || lat >= 60) break;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_rd_cycles"}, rd_cnt, exp_rd);
    check_eq({tag, "_mem_addr_bad"}, addr_bad, 0);

    e = exp_q.pop_front();
    for (int i = 0; i < rdy_dly; i++) begin
      check_eq({tag, "_hold_valid"}, resp_valid, 1);
      check_eq({tag, "_hold_req_ready"}, req_ready, 0);
      check_eq({tag, "_hold_data"}, resp_data, e);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    check_eq({tag, "_valid"}, resp_valid, 1);
    check_eq({tag, "_data"}, resp_data, e);
    check_eq({tag, "_misalign"}, resp_misalign, mis);
    check_eq({tag, "_buserr"}, resp_buserr, exp_bus);
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_post_valid"}, resp_valid, 0);
    check_eq({tag, "_post_flags"}, {resp_misalign, resp_buserr}, 0);
    check_eq({tag, "_post_req_ready"}, req_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not finish");
  end

  // ---------------- main sequence ----------------
  initial begin
    int quiet;
    mem_model[32'h100] = 32'h8899AABB;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_flags", {resp_misalign, resp_buserr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // lane selection and extension on 0x8899AABB
    run_load(32'h101, 2'b00, 1'b0, 2, 0, "lb_101");
    run_load(32'h103, 2'b00, 1'b1, 2, 0, "lbu_103");
    run_load(32'h102, 2'b01, 1'b0, 2, 0, "lh_102");
    run_load(32'h100, 2'b01, 1'b1, 2, 0, "lhu_100");
    run_load(32'h100, 2'b10, 1'b0, 2, 0, "lw_100");

    // misalignment and illegal size
    run_load(32'h101, 2'b01, 1'b0, 2, 0, "mis_lh_101");
    run_load(32'h102, 2'b10, 1'b0, 2, 0, "mis_lw_102");
    run_load(32'h100, 2'b11, 1'b0, 2, 0, "mis_size3");

    // timing and backpressure
    run_load(32'h100, 2'b00, 1'b0, 0, 0, "zero_wait");
    run_load(32'h100, 2'b10, 1'b0, 1, 5, "backpressure");
    run_load(32'h101, 2'b11, 1'b0, 0, 3, "mis_backpressure");

    // timeout and coincident ack
    ack_en = 1'b0;
    run_load(32'h100, 2'b10, 1'b0, 0, 0, "timeout_noack");
    ack_en = 1'b1;
    run_load(32'h100, 2'b00, 1'b0, T - 1, 0, "ack_on_last");
    run_load(32'h100, 2'b00, 1'b0, T, 1, "ack_too_late");

    // reset while the read is outstanding
    ack_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h104; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid_pre_rd", mem_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_mem_rd", mem_rd, 0);
    check_eq("rstmid_resp_valid", resp_valid, 0);
    check_eq("rstmid_flags", {resp_misalign, resp_buserr}, 0);
    check_eq("rstmid_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || mem_rd) quiet++;
    end
    check_eq("late_ack_ignored", quiet, 0);
    check_eq("late_ack_req_ready", req_ready, 1);
    ack_en = 1'b1;

    // random loads over a small memory window
    for (int a = 32'h100; a < 32'h140; a += 4) mem_model[a] = $urandom;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = 32'h100 + $urandom_range(0, 63);
      run_load(ra, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 5), $urandom_range(0, 3), "rand");
    end

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
